// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult
//   Radix-2 shift-and-add multiplier, one multiplier bit per clock.
//   Multiplies two WIDTH-bit operands, signed or unsigned per transaction,
//   and returns the full 2*WIDTH-bit product through a valid/ready handshake.
//   Signed operands are reduced to magnitudes on accept; the sign is applied
//   to the final accumulator as a modulo-2^(2*WIDTH) negation.
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands and mode valid this cycle
//   in_ready   operands can be accepted (IDLE only)
//   a, b       multiplicand, multiplier (WIDTH bits)
//   is_signed  1: a, b are two's complement; 0: unsigned
//   out_valid  product valid, held until taken
//   out_ready  consumer takes the product
//   product    a*b, 2*WIDTH bits
//   busy       iterating
module seq_shift_add_mult #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    ma, mb;
   logic                neg;
   logic [CW-1:0]       cnt;
   logic [2*WIDTH-1:0]  acc, acc_sum;
   logic [WIDTH-1:0]    mag_a, mag_b;
   logic                accept, last;

   // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is
   // exactly its unsigned magnitude, so no extra bit is needed.
   always_comb begin
      mag_a = (is_signed && a[WIDTH-1]) ? ('0 - a) : a;
      mag_b = (is_signed && b[WIDTH-1]) ? ('0 - b) : b;
   end

   always_comb begin
      acc_sum = acc;
      if (mb[cnt])
         acc_sum = acc + ({{WIDTH{1'b0}}, ma} << cnt);
   end

   assign accept = (state == IDLE) && in_valid;
   assign last   = (state == BUSY) && (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (cnt == CW'(WIDTH - 1))
               state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ma      <= '0;
         mb      <= '0;
         neg     <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         product <= '0;
      end else if (accept) begin
         ma  <= mag_a;
         mb  <= mag_b;
         neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
         cnt <= '0;
         acc <= '0;
      end else if (state == BUSY) begin
         acc <= acc_sum;
         cnt <= cnt + CW'(1);
         // A zero accumulator negates to zero, so no negative-zero guard.
         if (last)
            product <= neg ? ('0 - acc_sum) : acc_sum;
      end
   end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
`timescale 1ns/1ps
module tb_seq_shift_add_mult;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, out_ready, is_signed;
   logic [31:0] a_bus, b_bus;
   int          sel;

   logic        ir4, ov4, bz4, ir8, ov8, bz8, ir16, ov16, bz16;
   logic [7:0]  p4;
   logic [15:0] p8;
   logic [31:0] p16;

   logic        in_ready_m, out_valid_m, busy_m;
   logic [31:0] product_m;

   seq_shift_add_mult #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 4), .in_ready(ir4),
      .a(a_bus[3:0]), .b(b_bus[3:0]), .is_signed(is_signed), .out_valid(ov4),
      .out_ready(out_ready && sel == 4), .product(p4), .busy(bz4));

   seq_shift_add_mult #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 8), .in_ready(ir8),
      .a(a_bus[7:0]), .b(b_bus[7:0]), .is_signed(is_signed), .out_valid(ov8),
      .out_ready(out_ready && sel == 8), .product(p8), .busy(bz8));

   seq_shift_add_mult #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 16), .in_ready(ir16),
      .a(a_bus[15:0]), .b(b_bus[15:0]), .is_signed(is_signed), .out_valid(ov16),
      .out_ready(out_ready && sel == 16), .product(p16), .busy(bz16));

   always_comb begin
      case (sel)
         4: begin
            in_ready_m = ir4; out_valid_m = ov4; busy_m = bz4; product_m = {24'b0, p4};
         end
         16: begin
            in_ready_m = ir16; out_valid_m = ov16; busy_m = bz16; product_m = p16;
         end
         default: begin
            in_ready_m = ir8; out_valid_m = ov8; busy_m = bz8; product_m = {16'b0, p8};
         end
      endcase
   end

   int checks = 0;
   int fails  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: interpret operands per mode, multiply as integers, wrap to 2*w bits.
   function automatic logic [63:0] ref_mul(input int w, input logic [31:0] av,
                                           input logic [31:0] bv, input bit s);
      longint sa, sb, mask;
      mask = (longint'(1) << w) - 1;
      sa = longint'(av) & mask;
      sb = longint'(bv) & mask;
      if (s && ((sa >> (w - 1)) & 1) == 1) sa = sa - (longint'(1) << w);
      if (s && ((sb >> (w - 1)) & 1) == 1) sb = sb - (longint'(1) << w);
      return 64'((sa * sb) & ((longint'(1) << (2 * w)) - 1));
   endfunction

   // Runs one transaction on the selected instance; returns product and the
   // number of cycles from the accept edge to out_valid.
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input bit s,
                        output logic [31:0] p, output int lat);
      int guard = 0;
      while (!in_ready_m && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      a_bus = av; b_bus = bv; is_signed = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      a_bus     = $urandom;
      b_bus     = $urandom;
      is_signed = 1'($urandom);
      lat = 0;
      while (!out_valid_m && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      p = product_m;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      bit          s;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] p;
      int          lat;
      int          accepts[$];
      int          seen;
      logic [31:0] ra, rb;
      bit          rs;

      vecs[0] = '{8'd13,  8'd11,  1'b0, 16'd143};
      vecs[1] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
      vecs[2] = '{8'h80,  8'h80,  1'b1, 16'h4000};
      vecs[3] = '{8'h80,  8'h7F,  1'b1, 16'hC080};
      vecs[4] = '{8'hFF,  8'h01,  1'b1, 16'hFFFF};
      vecs[5] = '{8'h00,  8'hFB,  1'b1, 16'h0000};
      vecs[6] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
      vecs[7] = '{8'h7F,  8'h7F,  1'b1, 16'h3F01};
      vecs[8] = '{8'h80,  8'h80,  1'b0, 16'h4000};

      sel = 8; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a_bus = '0; b_bus = '0; is_signed = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      foreach (accepts[i]) accepts.delete(i);
      for (int k = 0; k < 3; k++) begin
         sel = (k == 0) ? 4 : (k == 1) ? 8 : 16;
         #1;
         check($sformatf("reset_in_ready_w%0d", sel), 64'(in_ready_m), 64'd1);
         check($sformatf("reset_out_valid_w%0d", sel), 64'(out_valid_m), 64'd0);
         check($sformatf("reset_busy_w%0d", sel), 64'(busy_m), 64'd0);
         check($sformatf("reset_product_w%0d", sel), 64'(product_m), 64'd0);
      end
      rst_n = 1'b1;
      sel = 8;
      @(posedge clk); #1;

      // Directed vectors at WIDTH=8
      for (int i = 0; i < 9; i++) begin
         do_op({24'b0, vecs[i].a}, {24'b0, vecs[i].b}, vecs[i].s, p, lat);
         check($sformatf("vec%0d_product", i), 64'(p), 64'(vecs[i].exp));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
      end

      // Output back-pressure: result held, new input ignored
      a_bus = 32'd200; b_bus = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("hold_out_valid_at_8", 64'(out_valid_m), 64'd1);
      check("hold_product_at_8", 64'(product_m), 64'h258);
      a_bus = 32'd7; b_bus = 32'd7; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("hold%0d_out_valid", i), 64'(out_valid_m), 64'd1);
         check($sformatf("hold%0d_product", i), 64'(product_m), 64'h258);
         check($sformatf("hold%0d_in_ready", i), 64'(in_ready_m), 64'd0);
         check($sformatf("hold%0d_busy", i), 64'(busy_m), 64'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("taken_out_valid", 64'(out_valid_m), 64'd0);
      check("taken_in_ready", 64'(in_ready_m), 64'd1);
      check("taken_product_kept", 64'(product_m), 64'h258);
      do_op(32'd3, 32'd3, 1'b0, p, lat);
      check("after_hold_product", 64'(p), 64'd9);
      check("after_hold_latency", 64'(lat), 64'd8);

      // Reset in the 4th BUSY cycle aborts the operation
      a_bus = 32'd100; b_bus = 32'd100; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("abort_busy_1st", 64'(busy_m), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_out_valid", 64'(out_valid_m), 64'd0);
      check("abort_product", 64'(product_m), 64'd0);
      check("abort_busy", 64'(busy_m), 64'd0);
      check("abort_in_ready", 64'(in_ready_m), 64'd1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid_m || busy_m) seen++;
      end
      check("abort_no_stale", 64'(seen), 64'd0);

      // Back-to-back with both handshakes tied high
      a_bus = 32'd7; b_bus = 32'd9; is_signed = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 52; i++) begin
         if (in_ready_m) accepts.push_back(i);
         if (out_valid_m) check($sformatf("b2b_product_c%0d", i), 64'(product_m), 64'd63);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("b2b_accept_count", 64'(accepts.size()), 64'd6);
      for (int i = 1; i < accepts.size(); i++)
         check($sformatf("b2b_interval%0d", i), 64'(accepts[i] - accepts[i-1]), 64'd10);

      // Exhaustive sweep at WIDTH=4
      sel = 4;
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++)
         for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++) begin
               do_op(32'(ia), 32'(ib), 1'(s), p, lat);
               check($sformatf("w4_%0d_%0dx%0d", s, ia, ib), 64'(p), ref_mul(4, 32'(ia), 32'(ib), 1'(s)));
               check($sformatf("w4_lat_%0d_%0dx%0d", s, ia, ib), 64'(lat), 64'd4);
            end

      // Random sweeps at WIDTH=8 and WIDTH=16
      for (int k = 0; k < 2; k++) begin
         sel = (k == 0) ? 8 : 16;
         @(posedge clk); #1;
         for (int i = 0; i < 200; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            if (i < 4) begin
               // Force the extreme operands into the sweep
               ra = (i[0]) ? 32'hFFFF_FFFF : 32'h0000_8080;
               rb = (i[1]) ? 32'h0000_8080 : 32'hFFFF_FFFF;
            end
            do_op(ra, rb, rs, p, lat);
            check($sformatf("w%0d_rand%0d", sel, i), 64'(p), ref_mul(sel, ra, rb, rs));
            check($sformatf("w%0d_rand_lat%0d", sel, i), 64'(lat), 64'(sel));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
